// File: rtl/sgpr_pkg.sv
// Shared types and constants for the shadow-GPR restore sequencer.
package sgpr_pkg;

    localparam int unsigned SGPR_NUM_REGS   = 16;
    localparam int unsigned SGPR_DATA_WIDTH = 32;
    localparam int unsigned SGPR_ADDR_WIDTH = 5;
    localparam int unsigned SGPR_FIRST_REG  = 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WRITE  = 2'd1,
        ST_VERIFY = 2'd2,
        ST_DONE   = 2'd3
    } sgpr_restore_state_e;

endpackage : sgpr_pkg

// File: rtl/sgpr_restore.sv
// Copies the shadow register file into the main RF (x1..xN-1), optionally
// reading every entry back and accumulating mismatch statistics.
module sgpr_restore
    import sgpr_pkg::*;
#(
    parameter int unsigned NUM_REGS   = SGPR_NUM_REGS,
    parameter int unsigned DATA_WIDTH = SGPR_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = SGPR_ADDR_WIDTH
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start_i,
    input  logic                             verify_en_i,
    input  logic                             abort_i,
    input  logic [NUM_REGS*DATA_WIDTH-1:0]   shadow_i,
    output logic [ADDR_WIDTH-1:0]            waddr_o,
    output logic [DATA_WIDTH-1:0]            wdata_o,
    output logic                             we_o,
    output logic [ADDR_WIDTH-1:0]            raddr_o,
    input  logic [DATA_WIDTH-1:0]            rdata_i,
    output logic                             busy_o,
    output logic                             done_o,
    output logic                             error_o,
    output logic [ADDR_WIDTH-1:0]            err_count_o,
    output logic [ADDR_WIDTH-1:0]            err_addr_o
);

    localparam int unsigned           IDX_W     = $clog2(NUM_REGS);
    localparam logic [ADDR_WIDTH-1:0] FIRST_IDX = ADDR_WIDTH'(SGPR_FIRST_REG);
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX  = ADDR_WIDTH'(NUM_REGS - 1);

    sgpr_restore_state_e     state_q, state_d;
    logic [ADDR_WIDTH-1:0]   idx_q, idx_d;
    logic                    verify_q, verify_d;
    logic                    error_q, error_d;
    logic [ADDR_WIDTH-1:0]   err_cnt_q, err_cnt_d;
    logic [ADDR_WIDTH-1:0]   err_addr_q, err_addr_d;

    logic [DATA_WIDTH-1:0]   shadow_arr [NUM_REGS];
    logic [DATA_WIDTH-1:0]   shadow_sel;
    logic                    is_last;
    logic                    mismatch;

    // Unpack the flat shadow bus so the current index can select one entry.
    for (genvar g = 0; g < int'(NUM_REGS); g++) begin : g_unpack
        assign shadow_arr[g] = shadow_i[g*DATA_WIDTH +: DATA_WIDTH];
    end

    assign shadow_sel = shadow_arr[idx_q[IDX_W-1:0]];
    assign is_last    = (idx_q == LAST_IDX);
    assign mismatch   = (state_q == ST_VERIFY) && (rdata_i != shadow_sel);

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        verify_d   = verify_q;
        error_d    = error_q;
        err_cnt_d  = err_cnt_q;
        err_addr_d = err_addr_q;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d    = ST_WRITE;
                    idx_d      = FIRST_IDX;
                    verify_d   = verify_en_i;
                    error_d    = 1'b0;
                    err_cnt_d  = '0;
                    err_addr_d = '0;
                end
            end
            ST_WRITE: begin
                if (abort_i) begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                end else if (is_last) begin
                    if (verify_q) begin
                        state_d = ST_VERIFY;
                        idx_d   = FIRST_IDX;
                    end else begin
                        state_d = ST_DONE;
                        idx_d   = '0;
                    end
                end else begin
                    idx_d = idx_q + ADDR_WIDTH'(1);
                end
            end
            ST_VERIFY: begin
                if (abort_i) begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                end else begin
                    // First mismatch is recognised by the count still being zero.
                    if (mismatch) begin
                        err_cnt_d = err_cnt_q + ADDR_WIDTH'(1);
                        error_d   = 1'b1;
                        if (err_cnt_q == '0) begin
                            err_addr_d = idx_q;
                        end
                    end
                    if (is_last) begin
                        state_d = ST_DONE;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + ADDR_WIDTH'(1);
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                idx_d   = '0;
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            verify_q   <= 1'b0;
            error_q    <= 1'b0;
            err_cnt_q  <= '0;
            err_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            verify_q   <= verify_d;
            error_q    <= error_d;
            err_cnt_q  <= err_cnt_d;
            err_addr_q <= err_addr_d;
        end
    end

    // Port outputs decode only registered state and index.
    assign we_o        = (state_q == ST_WRITE);
    assign waddr_o     = we_o ? idx_q : '0;
    assign wdata_o     = we_o ? shadow_sel : '0;
    assign raddr_o     = (state_q == ST_VERIFY) ? idx_q : '0;
    assign busy_o      = (state_q == ST_WRITE) || (state_q == ST_VERIFY);
    assign done_o      = (state_q == ST_DONE);
    assign error_o     = error_q;
    assign err_count_o = err_cnt_q;
    assign err_addr_o  = err_addr_q;

endmodule : sgpr_restore

// File: tb/tb_sgpr_restore.sv
// Self-checking bench for sgpr_restore: directed table, corner sequences and
// randomized operations against a per-cycle behavioural expectation.
module tb_sgpr_restore;

    localparam int NR = 16;
    localparam int DW = 32;
    localparam int AW = 5;

    logic            clk = 1'b0;
    logic            rst;
    logic            start_i;
    logic            verify_en_i;
    logic            abort_i;
    logic [NR*DW-1:0] shadow_bus;
    logic [AW-1:0]   waddr_o;
    logic [DW-1:0]   wdata_o;
    logic            we_o;
    logic [AW-1:0]   raddr_o;
    logic [DW-1:0]   rdata_i;
    logic            busy_o;
    logic            done_o;
    logic            error_o;
    logic [AW-1:0]   err_count_o;
    logic [AW-1:0]   err_addr_o;

    logic [DW-1:0]   sh [NR];
    logic [DW-1:0]   rf [NR];
    logic [15:0]     corrupt;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NR; g++) begin : g_pack
        assign shadow_bus[g*DW +: DW] = sh[g];
    end

    // Main register-file model: write on clock, combinational read with optional corruption.
    always @(posedge clk) begin
        if (we_o) rf[waddr_o[3:0]] <= wdata_o;
    end
    assign rdata_i = corrupt[raddr_o[3:0]] ? (rf[raddr_o[3:0]] ^ 32'hDEAD_BEEF)
                                           : rf[raddr_o[3:0]];

    sgpr_restore dut (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start_i),
        .verify_en_i (verify_en_i),
        .abort_i     (abort_i),
        .shadow_i    (shadow_bus),
        .waddr_o     (waddr_o),
        .wdata_o     (wdata_o),
        .we_o        (we_o),
        .raddr_o     (raddr_o),
        .rdata_i     (rdata_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .error_o     (error_o),
        .err_count_o (err_count_o),
        .err_addr_o  (err_addr_o)
    );

    typedef struct {
        logic        verify;
        logic [15:0] mask;
        int          abort_at;
        int          busy_start_at;
        logic        start_abort;
        int          exp_cnt;
        int          exp_addr;
    } vec_t;

    vec_t vecs [13];

    task automatic chk(input string name, input int cyc, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Runs one operation and checks every cycle against the timing rules:
    // writes in cycles 1..15, reads in 16..30 when verifying, done in the last cycle.
    task automatic run_op(input vec_t v);
        int  t_done;
        int  last;
        bit  live, ew, er;
        corrupt = v.mask;
        @(negedge clk);
        start_i     = 1'b1;
        verify_en_i = v.verify;
        abort_i     = v.start_abort;
        t_done = v.verify ? 31 : 16;
        last   = (v.abort_at > 0) ? v.abort_at + 3 : t_done + 1;
        for (int c = 1; c <= last; c++) begin
            @(negedge clk);
            start_i     = 1'b0;
            abort_i     = 1'b0;
            verify_en_i = 1'b0;
            live = (v.abort_at <= 0) || (c <= v.abort_at);
            ew   = live && (c <= 15);
            er   = live && v.verify && (c >= 16) && (c <= 30);
            chk("we",    c, 32'(we_o),    32'(ew));
            chk("waddr", c, 32'(waddr_o), ew ? 32'(c) : 32'd0);
            chk("wdata", c, wdata_o,      ew ? sh[c] : 32'd0);
            chk("raddr", c, 32'(raddr_o), er ? 32'(c - 15) : 32'd0);
            chk("busy",  c, 32'(busy_o),  32'(live && (c < t_done)));
            chk("done",  c, 32'(done_o),  32'(live && (c == t_done)));
            if (c == v.abort_at)      abort_i = 1'b1;
            if (c == v.busy_start_at) begin
                start_i     = 1'b1;
                verify_en_i = 1'b1;
            end
        end
        chk("err_count", 0, 32'(err_count_o), 32'(v.exp_cnt));
        chk("err_addr",  0, 32'(err_addr_o),  32'(v.exp_addr));
        chk("error",     0, 32'(error_o),     32'(v.exp_cnt != 0));
    endtask

    initial begin
        vec_t rv;
        rst         = 1'b1;
        start_i     = 1'b0;
        verify_en_i = 1'b0;
        abort_i     = 1'b0;
        corrupt     = '0;
        for (int k = 0; k < NR; k++) sh[k] = 32'(100 + k);

        //              verify mask     abort bstart s+a  cnt addr
        vecs[0]  = '{1'b0, 16'h0000,  0,  0, 1'b0,  0,  0};
        vecs[1]  = '{1'b1, 16'h0000,  0,  0, 1'b0,  0,  0};
        vecs[2]  = '{1'b1, 16'h1080,  0,  0, 1'b0,  2,  7};
        vecs[3]  = '{1'b1, 16'h8000,  0,  0, 1'b0,  1, 15};
        vecs[4]  = '{1'b1, 16'h8002,  0,  0, 1'b0,  2,  1};
        vecs[5]  = '{1'b1, 16'hFFFE,  0,  0, 1'b0, 15,  1};
        vecs[6]  = '{1'b0, 16'h1080,  0,  8, 1'b0,  0,  0};
        vecs[7]  = '{1'b1, 16'h0000,  0, 31, 1'b0,  0,  0};
        vecs[8]  = '{1'b0, 16'h0000,  0, 16, 1'b0,  0,  0};
        vecs[9]  = '{1'b0, 16'h0000,  5,  0, 1'b0,  0,  0};
        vecs[10] = '{1'b0, 16'h0000,  0,  0, 1'b1,  0,  0};
        vecs[11] = '{1'b1, 16'h0004, 19,  0, 1'b0,  1,  2};
        vecs[12] = '{1'b1, 16'h0000,  0,  0, 1'b0,  0,  0};

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_we",    0, 32'(we_o),        32'd0);
        chk("rst_busy",  0, 32'(busy_o),      32'd0);
        chk("rst_done",  0, 32'(done_o),      32'd0);
        chk("rst_raddr", 0, 32'(raddr_o),     32'd0);
        chk("rst_waddr", 0, 32'(waddr_o),     32'd0);
        chk("rst_error", 0, 32'(error_o),     32'd0);
        chk("rst_cnt",   0, 32'(err_count_o), 32'd0);
        chk("rst_addr",  0, 32'(err_addr_o),  32'd0);
        rst = 1'b0;

        for (int i = 0; i < 13; i++) begin
            run_op(vecs[i]);
        end

        // Reset during the 9th write.
        @(negedge clk);
        start_i     = 1'b1;
        verify_en_i = 1'b1;
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            start_i     = 1'b0;
            verify_en_i = 1'b0;
            chk("pre_rst_waddr", c, 32'(waddr_o), 32'(c));
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("post_rst_we",    10, 32'(we_o),        32'd0);
        chk("post_rst_waddr", 10, 32'(waddr_o),     32'd0);
        chk("post_rst_wdata", 10, wdata_o,          32'd0);
        chk("post_rst_raddr", 10, 32'(raddr_o),     32'd0);
        chk("post_rst_busy",  10, 32'(busy_o),      32'd0);
        chk("post_rst_done",  10, 32'(done_o),      32'd0);
        chk("post_rst_cnt",   10, 32'(err_count_o), 32'd0);
        repeat (3) @(negedge clk);
        chk("post_rst_idle",  13, 32'(busy_o),      32'd0);

        // Randomized operations against a rule-level error model.
        for (int r = 0; r < 12; r++) begin
            for (int k = 0; k < NR; k++) sh[k] = $urandom;
            rv.verify        = 1'($urandom_range(0, 1));
            rv.mask          = 16'($urandom) & 16'hFFFE;
            rv.abort_at      = 0;
            rv.busy_start_at = (($urandom_range(0, 1) == 1) ? $urandom_range(1, 14) : 0);
            rv.start_abort   = 1'($urandom_range(0, 1));
            rv.exp_cnt       = 0;
            rv.exp_addr      = 0;
            if (rv.verify) begin
                for (int k = 15; k >= 1; k--) begin
                    if (rv.mask[k]) begin
                        rv.exp_cnt++;
                        rv.exp_addr = k;
                    end
                end
            end
            run_op(rv);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_sgpr_restore

// File: doc/sgpr_restore.md
# sgpr_restore

Recovery sequencer that copies the shadow general-purpose register file back into the core's main register file after a fault. It sits between the `sgpr` shadow file, whose full contents arrive on `shadow_i`, and the main register file's write and read ports. On request it writes registers x1..x(NUM_REGS-1) one per cycle. It can optionally read them back and compare against the shadow, reporting the mismatch count and the first mismatching address.

## Interface
- `NUM_REGS`, 16: entries in the shadow file; x0 is never written or verified.
- `DATA_WIDTH`, 32: register width.
- `ADDR_WIDTH`, 5: register-file address width.

- `clk`  in  1: sole clock, rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `start_i`  in  1: begin a restore; sampled only in IDLE.
- `verify_en_i`  in  1: sampled with `start_i`; 1 selects restore-then-verify.
- `abort_i`  in  1: cancel an operation in progress.
- `shadow_i`  in  NUM_REGS×DATA_WIDTH: live shadow contents (the `rf_reg` bus).
- `waddr_o`  out  ADDR_WIDTH: main RF write address.
- `wdata_o`  out  DATA_WIDTH: main RF write data.
- `we_o`  out  1: main RF write enable.
- `raddr_o`  out  ADDR_WIDTH: main RF read address for verify.
- `rdata_i`  in  DATA_WIDTH: main RF read data; combinational, same cycle as `raddr_o`.
- `busy_o`  out  1: operation in progress; also used as core halt.
- `done_o`  out  1: one-cycle completion pulse.
- `error_o`  out  1: at least one verify mismatch in the last operation.
- `err_count_o`  out  ADDR_WIDTH: mismatches in the last verify.
- `err_addr_o`  out  ADDR_WIDTH: first mismatching address; 0 if none.

## Operation
- States: IDLE, WRITE, VERIFY, DONE. One index counter `idx` (ADDR_WIDTH).
- IDLE:
  - `start_i`=1 → WRITE, `idx`←1, latch `verify_en_i`, clear `error_o`, `err_count_o`, `err_addr_o`.
  - Otherwise stay in IDLE.
- WRITE:
  - `we_o`=1, `waddr_o`=`idx`, `wdata_o`=`shadow_i[idx]`.
  - At `idx`=NUM_REGS-1 → VERIFY (`idx`←1) if verify was latched, else → DONE. Otherwise `idx`++.
- VERIFY:
  - `we_o`=0, `raddr_o`=`idx`.
  - Mismatch when `rdata_i`≠`shadow_i[idx]`: `err_count_o`++, `error_o`←1, and `err_addr_o`←`idx` if this is the first mismatch.
  - At `idx`=NUM_REGS-1 → DONE, else `idx`++.
- DONE: `done_o`=1 for exactly one cycle, then → IDLE. `busy_o`=0 in DONE.
- `busy_o`=1 in WRITE and VERIFY only.
- Error outputs hold their value until the next accepted start or reset.
- `err_count_o` cannot overflow: at most NUM_REGS-1=15 mismatches, which fits in 5 bits.
- `abort_i` in WRITE or VERIFY → IDLE next cycle; no `done_o`, error outputs keep partial values. `abort_i` in IDLE or DONE is ignored.
- `start_i` outside IDLE is ignored and is not queued.
- Simultaneous `start_i` and `abort_i` in IDLE: start wins.
- `shadow_i` is not snapshotted. The integrator must block shadow writes while `busy_o`=1.
- Outside VERIFY: `raddr_o`=0. Outside WRITE: `waddr_o`=0, `wdata_o`=0, `we_o`=0.

## Timing
- Reset: state IDLE, `idx`=0, all outputs 0.
- Reset is synchronous and overrides any state, including mid-WRITE. `we_o` is low in the cycle after the reset edge.
- Restore only: `start_i` at edge N → writes at cycles N+1..N+15 → `done_o` at N+16 → IDLE at N+17.
- Restore + verify: writes at N+1..N+15, reads at N+16..N+30, `done_o` at N+31.
- The write to x15 is visible to a read at the first VERIFY cycle (x1 is read first), so no bubble is needed between WRITE and VERIFY.
- Outputs are decoded from registered state and `idx` (Moore). `wdata_o` and the compare path are combinational from `shadow_i` and `rdata_i`.
- Minimum start-to-start spacing is 17 cycles (restore only) or 32 cycles (with verify).

## Structure
- Package `sgpr_pkg`:
  - state enum `sgpr_restore_state_e`;
  - constants `SGPR_NUM_REGS`, `SGPR_DATA_WIDTH`, `SGPR_ADDR_WIDTH`;
  - localparam `SGPR_FIRST_REG`=1.
- Single module, no sub-modules. The FSM and index counter share one sequential process. The compare/error accumulator lives in the same module.

## Test plan
- Reset, then `shadow_i[k]`=100+k and `start_i` pulse with `verify_en_i`=0 → `we_o` high for 15 cycles with `waddr_o`=1..15 and `wdata_o`=101..115; `done_o` at cycle 16; `error_o`=0.
- Same stimulus with `verify_en_i`=1, bench RF model correct → `raddr_o` sweeps 1..15, `done_o` at cycle 31, `err_count_o`=0, `err_addr_o`=0.
- Verify with the RF model corrupting x7 and x12 → `error_o`=1, `err_count_o`=2, `err_addr_o`=7.
- `abort_i` during the 5th write → `we_o`=0 next cycle, no `done_o`, `busy_o`=0. A new `start_i` restarts from x1.
- `rst` asserted during the 9th write → all outputs 0 on the next cycle. `start_i` asserted while busy has no effect, and the cycle count is unchanged.
- `start_i` and `abort_i` asserted together in IDLE → operation starts, `waddr_o`=1 next cycle.
